// File: rtl/seqdet_pkg.sv
// Shared constants and elaboration-time KMP helpers for the serial pattern detector.
package seqdet_pkg;

   localparam int unsigned MAX_LEN = 16;

   function automatic int unsigned state_w(input int unsigned len);
      return (len < 2) ? 1 : $clog2(len);
   endfunction

   function automatic bit len_ok(input int unsigned len);
      return (len >= 2) && (len <= MAX_LEN);
   endfunction

   // Pattern bit in arrival order: index 0 is the first bit on the line.
   function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern,
                                    input int unsigned len, input int unsigned i);
      logic [MAX_LEN-1:0] t;
      t = pattern >> (len - 1 - i);
      return t[0];
   endfunction

   function automatic logic seq_bit(input logic [MAX_LEN:0] s, input int unsigned i);
      logic [MAX_LEN:0] t;
      t = s >> i;
      return t[0];
   endfunction

   // Longest proper pattern prefix that is a suffix of (matched prefix ++ b).
   function automatic int unsigned kmp_next(input logic [MAX_LEN-1:0] pattern,
                                            input int unsigned len,
                                            input int unsigned state,
                                            input logic b);
      logic [MAX_LEN:0] s;
      int unsigned      n;
      int unsigned      res;
      bit               ok;
      s = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (i < state)
            s = s | ((MAX_LEN+1)'(pat_bit(pattern, len, i)) << i);
      end
      s   = s | ((MAX_LEN+1)'(b) << state);
      n   = state + 1;
      res = 0;
      for (int unsigned j = 1; j <= MAX_LEN; j++) begin
         if ((j < len) && (j <= n)) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
               if ((i < j) && (pat_bit(pattern, len, i) != seq_bit(s, n - j + i)))
                  ok = 1'b0;
            end
            if (ok)
               res = j;
         end
      end
      return res;
   endfunction

   // Border of the whole pattern: where an overlapping match resumes.
   function automatic int unsigned kmp_fail(input logic [MAX_LEN-1:0] pattern,
                                            input int unsigned len);
      return kmp_next(pattern, len, len - 1, pat_bit(pattern, len, len - 1));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + W'(1);
         sat <= (cnt == (CNT_MAX - W'(1)));
      end
   end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with KMP fallback and saturating match count.
module mealy_seq_detector
   import seqdet_pkg::*;
#(
   parameter int unsigned             PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0]  PATTERN     = 4'b1011,
   parameter bit                      OVERLAP     = 1'b1,
   parameter int unsigned             COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   input  logic               cnt_clr,
   output logic               out,
   output logic               out_r,
   output logic [COUNT_W-1:0] match_cnt,
   output logic               cnt_sat
);

   localparam int unsigned        SW       = state_w(PATTERN_LEN);
   localparam int unsigned        NS       = 2 ** SW;
   localparam logic [MAX_LEN-1:0] PAT_EXT  = MAX_LEN'(PATTERN);
   localparam logic [SW-1:0]      LAST     = SW'(PATTERN_LEN - 1);
   localparam logic               LAST_BIT = PATTERN[0];

   if (!len_ok(PATTERN_LEN)) begin : g_bad_len
      $error("mealy_seq_detector: PATTERN_LEN must be in 2..16");
   end

   logic [SW-1:0] r_state;
   logic [SW-1:0] w_state_nxt;
   logic          w_match;
   logic [SW-1:0] w_nxt_tbl [2*NS];

   // Transition table indexed by {state, bit}; unreachable states park at 0.
   for (genvar k = 0; k < NS; k++) begin : g_tbl
      if (k < PATTERN_LEN) begin : g_live
         assign w_nxt_tbl[2*k]   = SW'(kmp_next(PAT_EXT, PATTERN_LEN, k, 1'b0));
         assign w_nxt_tbl[2*k+1] = SW'(kmp_next(PAT_EXT, PATTERN_LEN, k, 1'b1));
      end else begin : g_dead
         assign w_nxt_tbl[2*k]   = '0;
         assign w_nxt_tbl[2*k+1] = '0;
      end
   end

   assign w_match = in_valid & (r_state == LAST) & (in == LAST_BIT);
   assign out     = w_match & ~rst;

   always_comb begin
      w_state_nxt = r_state;
      if (in_valid) begin
         if (w_match && !OVERLAP)
            w_state_nxt = '0;
         else
            w_state_nxt = w_nxt_tbl[{r_state, in}];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= '0;
         out_r   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         out_r   <= w_match;
      end
   end

   sat_counter #(.W(COUNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_match),
      .clr (cnt_clr),
      .cnt (match_cnt),
      .sat (cnt_sat)
   );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed bench: three detector configurations share one serial stimulus stream.
module tb_mealy_seq_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       cnt_clr;

   logic       a_out, a_out_r, a_sat;
   logic [7:0] a_cnt;
   logic       b_out, b_out_r, b_sat;
   logic [7:0] b_cnt;
   logic       c_out, c_out_r, c_sat;
   logic [1:0] c_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   mealy_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cnt_clr(cnt_clr),
      .out(a_out), .out_r(a_out_r), .match_cnt(a_cnt), .cnt_sat(a_sat));

   mealy_seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cnt_clr(cnt_clr),
      .out(b_out), .out_r(b_out_r), .match_cnt(b_cnt), .cnt_sat(b_sat));

   mealy_seq_detector #(.PATTERN_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .COUNT_W(2)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cnt_clr(cnt_clr),
      .out(c_out), .out_r(c_out_r), .match_cnt(c_cnt), .cnt_sat(c_sat));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic b, input logic clr);
      @(negedge clk);
      in_valid = v;
      in_bit   = b;
      cnt_clr  = clr;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      cnt_clr  = 1'b0;
      #2 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   bit t1_in [7] = '{1, 0, 1, 1, 0, 1, 1};
   bit t1_ea [7] = '{0, 0, 0, 1, 0, 0, 1};
   bit t1_eb [7] = '{0, 0, 0, 1, 0, 0, 0};
   bit t2_in [6] = '{1, 0, 1, 0, 1, 1};
   bit t2_ea [6] = '{0, 0, 0, 0, 0, 1};

   initial begin
      int unsigned exp_cnt;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      cnt_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out",   32'(a_out),   0);
      chk("rst_out_r", 32'(a_out_r), 0);
      chk("rst_cnt",   32'(a_cnt),   0);
      chk("rst_sat",   32'(a_sat),   0);
      chk("rst_c_cnt", 32'(c_cnt),   0);
      @(negedge clk);
      rst = 1'b0;

      // Overlapping vs non-overlapping on the same stream
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, t1_in[i], 1'b0);
         chk($sformatf("t1_ovl_out_bit%0d", i + 1),  32'(a_out), 32'(t1_ea[i]));
         chk($sformatf("t1_novl_out_bit%0d", i + 1), 32'(b_out), 32'(t1_eb[i]));
      end
      idle();
      chk("t1_ovl_cnt",    32'(a_cnt),   2);
      chk("t1_novl_cnt",   32'(b_cnt),   1);
      chk("t1_ovl_out_r",  32'(a_out_r), 1);
      chk("t1_novl_out_r", 32'(b_out_r), 0);

      // KMP fallback: 1010 drops to state 2, then 11 completes
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, t2_in[i], 1'b0);
         chk($sformatf("t2_out_bit%0d", i + 1), 32'(a_out), 32'(t2_ea[i]));
      end
      idle();
      chk("t2_cnt", 32'(a_cnt), 1);

      // Idle gap inside the pattern
      pulse_reset();
      drive(1'b1, 1'b1, 1'b0);
      chk("t3_out_b1", 32'(a_out), 0);
      drive(1'b1, 1'b0, 1'b0);
      chk("t3_out_b2", 32'(a_out), 0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         chk($sformatf("t3_out_idle%0d", i), 32'(a_out), 0);
      end
      drive(1'b1, 1'b1, 1'b0);
      chk("t3_out_b3", 32'(a_out), 0);
      drive(1'b1, 1'b1, 1'b0);
      chk("t3_out_b4", 32'(a_out), 1);
      idle();
      chk("t3_cnt",   32'(a_cnt),   1);
      chk("t3_out_r", 32'(a_out_r), 1);

      // Asynchronous reset with a match pending on the line
      pulse_reset();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      chk("t4_out_pre_rst", 32'(a_out), 1);
      rst = 1'b1;
      #1;
      chk("t4_out_in_rst",   32'(a_out),   0);
      chk("t4_out_r_in_rst", 32'(a_out_r), 0);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      drive(1'b1, 1'b1, 1'b0);
      chk("t4_out_after_rst", 32'(a_out), 0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      chk("t4_out_b3", 32'(a_out), 0);
      drive(1'b1, 1'b1, 1'b0);
      chk("t4_out_b4", 32'(a_out), 1);
      idle();
      chk("t4_cnt", 32'(a_cnt), 1);

      // Pattern 11 on a run of ones: six matches saturate a 2-bit counter
      pulse_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         exp_cnt = (i > 0) ? i - 1 : 0;
         if (exp_cnt > 3) exp_cnt = 3;
         chk($sformatf("t5_out_bit%0d", i + 1), 32'(c_out), (i == 0) ? 0 : 1);
         chk($sformatf("t5_cnt_bit%0d", i + 1), 32'(c_cnt), exp_cnt);
         chk($sformatf("t5_sat_bit%0d", i + 1), 32'(c_sat), (exp_cnt == 3) ? 1 : 0);
      end
      idle();
      chk("t5_cnt_final", 32'(c_cnt), 3);
      chk("t5_sat_final", 32'(c_sat), 1);

      // Clear coincident with a match: out pulses, match not counted
      drive(1'b1, 1'b1, 1'b1);
      chk("t6_out_clr", 32'(c_out), 1);
      idle();
      chk("t6_cnt_clr",   32'(c_cnt),   0);
      chk("t6_sat_clr",   32'(c_sat),   0);
      chk("t6_out_r_clr", 32'(c_out_r), 1);
      drive(1'b1, 1'b1, 1'b0);
      chk("t6_out_next", 32'(c_out), 1);
      idle();
      chk("t6_cnt_next", 32'(c_cnt), 1);
      chk("t6_sat_next", 32'(c_sat), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
